// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle MIPS datapath.
// A registered state machine walks each instruction through FETCH, DECODE,
// execute and writeback, and decodes the datapath mux selects and write
// enables from the current state. Memory states use a req/ready handshake
// with a bounded wait. Reaching the bound aborts the instruction and
// refetches from the unchanged PC.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              run enable (sampled in IDLE and at instruction completion)
//   opcode          IR[31:26]
//   zero            ALU zero flag (gated in the datapath, not used here)
//   mem_ready       memory completes the current access this cycle
//   mem_req, MemRead, MemWrite, IorD                  memory interface
//   IRWrite, PCWrite, PCWriteCond, PCSrc              IR / PC control
//   ALUSrcA, ALUSrcB, ALUOp, imm_op, zero_ext         ALU control
//   RegDst, MemtoReg, RegWrite                        register-file control
//   state           current state code
//   instr_done, illegal_op, bus_err                   one-cycle event pulses
//   instr_count     retired-instruction counter (wraps)
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       imm_op,
  output logic             zero_ext,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StRtEx   = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9,
    StImmEx  = 4'd10,
    StImmWb  = 4'd11,
    StJump   = 4'd12
  } state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               timeout;
  logic               done;

  // The branch decision is taken in the datapath (PCWriteCond & zero).
  logic unused_zero;
  assign unused_zero = zero;

  // Only meaningful in the memory states; ready on the last allowed cycle wins.
  assign timeout = (wait_q == TimeoutVal) && !mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    imm_op      = 2'b00;
    zero_ext    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    bus_err     = 1'b0;
    done        = 1'b0;

    case (state_q)
      StIdle: begin
        if (en) state_d = StFetch;
      end
      StFetch: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (mem_ready) begin
          // PC+4 and IR load only once the instruction word is actually there
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StDecode: begin
        // Speculative branch target: PC + (imm << 2)
        ALUSrcB = 2'b11;
        case (opcode)
          OpLw, OpSw:                             state_d = StMemAdr;
          OpRtype:                                state_d = StRtEx;
          OpBeq:                                  state_d = StBranch;
          OpAddi, OpAddiu, OpAndi, OpOri, OpLui:  state_d = StImmEx;
          OpJ:                                    state_d = StJump;
          default: begin
            illegal_op = 1'b1;
            state_d    = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        done     = 1'b1;
      end
      StMemWr: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        // Drop the write strobe on the aborting cycle
        MemWrite = !timeout;
        if (mem_ready) begin
          done = 1'b1;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StRtEx: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        done     = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        done        = 1'b1;
      end
      StImmEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        case (opcode)
          OpAndi: begin
            imm_op   = 2'b01;
            zero_ext = 1'b1;
          end
          OpOri: begin
            imm_op   = 2'b10;
            zero_ext = 1'b1;
          end
          OpLui:   imm_op = 2'b11;
          default: imm_op = 2'b00;
        endcase
        state_d = StImmWb;
      end
      StImmWb: begin
        RegWrite = 1'b1;
        done     = 1'b1;
      end
      StJump: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
        done    = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (done) state_d = en ? StFetch : StIdle;
  end

  // Wait counter restarts on every state entry, including the refetch after
  // an abort, and only counts cycles with an outstanding request.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || bus_err) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  assign count_d = done ? count_q + CNT_W'(1) : count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign instr_done  = done;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each scenario is a table of
// per-cycle inputs with hand-derived state, control word and counter values.
module tb_multicycle_control_fsm;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Control word layout:
  // {mem_req,MemRead,MemWrite,IorD}, {IRWrite,PCWrite,PCWriteCond}, PCSrc,
  // ALUSrcA, ALUSrcB, ALUOp, imm_op, zero_ext, {RegDst,MemtoReg,RegWrite},
  // {instr_done,illegal_op,bus_err}
  localparam logic [22:0] C_IDLE       = '0;
  localparam logic [22:0] C_FETCH_WAIT = {4'b1100, 3'b000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_FETCH_RDY  = {4'b1100, 3'b110, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_FETCH_TO   = {4'b1100, 3'b000, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b001};
  localparam logic [22:0] C_DECODE     = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_DECODE_ILL = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b010};
  localparam logic [22:0] C_MEMADR     = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_MEMRD      = {4'b1101, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_MEMRD_TO   = {4'b1101, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b001};
  localparam logic [22:0] C_MEMWB      = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b011, 3'b100};
  localparam logic [22:0] C_MEMWR_WAIT = {4'b1011, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_MEMWR_RDY  = {4'b1011, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b100};
  localparam logic [22:0] C_RTEX       = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0,
                                          3'b000, 3'b000};
  localparam logic [22:0] C_ALUWB      = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b101, 3'b100};
  localparam logic [22:0] C_BRANCH     = {4'b0000, 3'b001, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 1'b0,
                                          3'b000, 3'b100};
  localparam logic [22:0] C_IMMWB      = {4'b0000, 3'b000, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b001, 3'b100};
  localparam logic [22:0] C_JUMP       = {4'b0000, 3'b010, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0,
                                          3'b000, 3'b100};

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        rdy;
    logic [5:0]  op;
    logic [3:0]  st;
    logic [22:0] ctl;
    logic [3:0]  cnt;
  } row_t;

  logic            clk;
  logic            rst;
  logic            en;
  logic [5:0]      opcode;
  logic            zero;
  logic            mem_ready;
  logic            mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond;
  logic [1:0]      PCSrc;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB, ALUOp, imm_op;
  logic            zero_ext, RegDst, MemtoReg, RegWrite;
  logic [3:0]      state;
  logic            instr_done, illegal_op, bus_err;
  logic [CntW-1:0] instr_count;
  logic [22:0]     ctrl;

  int tests = 0;
  int fails = 0;

  multicycle_control_fsm #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .PCSrc      (PCSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .imm_op     (imm_op),
    .zero_ext   (zero_ext),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .state      (state),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .bus_err    (bus_err),
    .instr_count(instr_count)
  );

  assign ctrl = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
                 ALUSrcA, ALUSrcB, ALUOp, imm_op, zero_ext, RegDst, MemtoReg, RegWrite,
                 instr_done, illegal_op, bus_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  function automatic row_t mk(input logic r_rst, input logic r_en, input logic r_rdy,
                              input logic [5:0] r_op, input logic [3:0] r_st,
                              input logic [22:0] r_ctl, input logic [3:0] r_cnt);
    row_t x;
    x.rst = r_rst;
    x.en  = r_en;
    x.rdy = r_rdy;
    x.op  = r_op;
    x.st  = r_st;
    x.ctl = r_ctl;
    x.cnt = r_cnt;
    return x;
  endfunction

  // Leaves the DUT in IDLE at 1 time unit after a rising edge.
  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    mem_ready = 1'b0;
    opcode    = OP_R;
    zero      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 1, OP_J, 4'd0,  C_IDLE,      4'd0));
    rows.push_back(mk(0, 1, 1, OP_J, 4'd1,  C_FETCH_RDY, 4'd0));
    rows.push_back(mk(0, 1, 1, OP_J, 4'd2,  C_DECODE,    4'd0));
    rows.push_back(mk(0, 1, 1, OP_J, 4'd12, C_JUMP,      4'd0));
    rows.push_back(mk(1, 1, 1, OP_J, 4'd1,  C_FETCH_RDY, 4'd1));
    // mem_ready in IDLE must not start anything
    rows.push_back(mk(0, 0, 1, OP_J, 4'd0,  C_IDLE,      4'd0));
    rows.push_back(mk(0, 0, 1, OP_J, 4'd0,  C_IDLE,      4'd0));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL reset[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 1, OP_R, 4'd0, C_IDLE,       4'd0));
    rows.push_back(mk(0, 1, 1, OP_R, 4'd1, C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 1, OP_R, 4'd2, C_DECODE,     4'd0));
    rows.push_back(mk(0, 1, 1, OP_R, 4'd7, C_RTEX,       4'd0));
    rows.push_back(mk(0, 1, 1, OP_R, 4'd8, C_ALUWB,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_R, 4'd1, C_FETCH_WAIT, 4'd1));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL rtype[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // Ready arrives on the 4th MEMRD cycle, the same cycle the wait bound hits.
  task automatic test_lw_wait();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd0, C_IDLE,       4'd0));
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd1, C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd2, C_DECODE,     4'd0));
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd3, C_MEMADR,     4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd5, C_MEMWB,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_WAIT, 4'd1));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL lw_wait[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm_ops();
    logic [5:0]  ops  [5];
    logic [1:0]  imms [5];
    logic        zes  [5];
    logic [22:0] immex;
    row_t        rows[$];
    ops[0] = 6'b001000; imms[0] = 2'b00; zes[0] = 1'b0;
    ops[1] = 6'b001100; imms[1] = 2'b01; zes[1] = 1'b1;
    ops[2] = 6'b001101; imms[2] = 2'b10; zes[2] = 1'b1;
    ops[3] = 6'b001111; imms[3] = 2'b11; zes[3] = 1'b0;
    ops[4] = 6'b001001; imms[4] = 2'b00; zes[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      do_reset();
      immex = {4'b0000, 3'b000, 2'b00, 1'b1, 2'b10, 2'b11, imms[k], zes[k], 3'b000, 3'b000};
      rows.delete();
      rows.push_back(mk(0, 1, 1, ops[k], 4'd0,  C_IDLE,       4'd0));
      rows.push_back(mk(0, 1, 1, ops[k], 4'd1,  C_FETCH_RDY,  4'd0));
      rows.push_back(mk(0, 1, 1, ops[k], 4'd2,  C_DECODE,     4'd0));
      rows.push_back(mk(0, 1, 1, ops[k], 4'd10, immex,        4'd0));
      rows.push_back(mk(0, 1, 1, ops[k], 4'd11, C_IMMWB,      4'd0));
      rows.push_back(mk(0, 1, 0, ops[k], 4'd1,  C_FETCH_WAIT, 4'd1));
      for (int i = 0; i < rows.size(); i++) begin
        rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
        #1;
        tests++;
        if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
          fails++;
          $display("FAIL imm op=%b [%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                   ops[k], i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_illegal();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 1, OP_BAD, 4'd0,  C_IDLE,       4'd0));
    rows.push_back(mk(0, 1, 1, OP_BAD, 4'd1,  C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 1, OP_BAD, 4'd2,  C_DECODE_ILL, 4'd0));
    rows.push_back(mk(0, 1, 1, OP_J,   4'd1,  C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 1, OP_J,   4'd2,  C_DECODE,     4'd0));
    rows.push_back(mk(0, 1, 1, OP_J,   4'd12, C_JUMP,       4'd0));
    rows.push_back(mk(0, 1, 0, OP_J,   4'd1,  C_FETCH_WAIT, 4'd1));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL illegal[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // Fetch abort after 4 cycles, refetch succeeds, then a load aborts in MEMRD.
  task automatic test_timeout();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd0, C_IDLE,       4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_WAIT, 4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_WAIT, 4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_WAIT, 4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_TO,   4'd0));
    rows.push_back(mk(0, 1, 1, OP_LW, 4'd1, C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd2, C_DECODE,     4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd3, C_MEMADR,     4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD,      4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd4, C_MEMRD_TO,   4'd0));
    rows.push_back(mk(0, 1, 0, OP_LW, 4'd1, C_FETCH_WAIT, 4'd0));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL timeout[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // beq then en=0 parks in IDLE; a store completes; a second store is cut by rst.
  task automatic test_back_to_back();
    row_t rows[$];
    do_reset();
    rows.push_back(mk(0, 1, 1, OP_BEQ, 4'd0, C_IDLE,       4'd0));
    rows.push_back(mk(0, 1, 1, OP_BEQ, 4'd1, C_FETCH_RDY,  4'd0));
    rows.push_back(mk(0, 1, 1, OP_BEQ, 4'd2, C_DECODE,     4'd0));
    rows.push_back(mk(0, 0, 1, OP_BEQ, 4'd9, C_BRANCH,     4'd0));
    rows.push_back(mk(0, 0, 1, OP_SW,  4'd0, C_IDLE,       4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd0, C_IDLE,       4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd1, C_FETCH_RDY,  4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd2, C_DECODE,     4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd3, C_MEMADR,     4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd6, C_MEMWR_RDY,  4'd1));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd1, C_FETCH_RDY,  4'd2));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd2, C_DECODE,     4'd2));
    rows.push_back(mk(0, 1, 1, OP_SW,  4'd3, C_MEMADR,     4'd2));
    rows.push_back(mk(1, 1, 0, OP_SW,  4'd6, C_MEMWR_WAIT, 4'd2));
    rows.push_back(mk(0, 0, 0, OP_SW,  4'd0, C_IDLE,       4'd0));
    rows.push_back(mk(0, 0, 1, OP_SW,  4'd0, C_IDLE,       4'd0));
    for (int i = 0; i < rows.size(); i++) begin
      rst = rows[i].rst; en = rows[i].en; mem_ready = rows[i].rdy; opcode = rows[i].op;
      #1;
      tests++;
      if (state !== rows[i].st || ctrl !== rows[i].ctl || instr_count !== rows[i].cnt) begin
        fails++;
        $display("FAIL back_to_back[%0d]: state=%0d ctrl=%b count=%0d, expected state=%0d ctrl=%b count=%0d",
                 i, state, ctrl, instr_count, rows[i].st, rows[i].ctl, rows[i].cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  // 4-bit counter: 15 jumps give all-ones, the 16th wraps to zero.
  task automatic test_count_wrap();
    do_reset();
    en        = 1'b1;
    mem_ready = 1'b1;
    opcode    = OP_J;
    repeat (1 + 15 * 3) begin
      @(posedge clk); #1;
    end
    #1;
    tests++;
    if (instr_count !== 4'hF || state !== 4'd1) begin
      fails++;
      $display("FAIL count_full: count=%0d state=%0d, expected count=15 state=1",
               instr_count, state);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1;
    tests++;
    if (instr_count !== 4'h0 || state !== 4'd1) begin
      fails++;
      $display("FAIL count_wrap: count=%0d state=%0d, expected count=0 state=1",
               instr_count, state);
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    opcode    = OP_R;
    zero      = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_imm_ops();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
